addkey_stream: RTL

//  Streaming AES AddRoundKey stage: XORs each incoming state block with one of NUM_KEYS

---
 rtl/aes_pkg.sv | 14 +
 rtl/addkey_stream_if.sv | 30 +++
 rtl/addkey_keytab.sv | 44 ++++
 rtl/addkey_stream.sv | 72 +++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block type, byte width and the round-key counts
// used by the AES-128/192/256 key schedules.
package aes_pkg;

  localparam int BYTE_W      = 8;
  localparam int AES_BLOCK_W = 128;

  localparam int NK128 = 11;
  localparam int NK192 = 13;
  localparam int NK256 = 15;

  typedef logic [AES_BLOCK_W-1:0] block_t;

endpackage

// File: rtl/addkey_stream_if.sv
// Valid/ready stream bundle for the AddRoundKey stage: an input side carrying
// block + key index and an output side carrying the keyed block + index.
interface addkey_stream_if #(
  parameter int BLOCK_W = 128,
  parameter int KIDX_W  = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic [KIDX_W-1:0]  in_kidx;

  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic [KIDX_W-1:0]  out_kidx;

  // The stage itself: consumes the input side, produces the output side.
  modport slave (
    input  in_valid, in_data, in_kidx, out_ready,
    output in_ready, out_valid, out_data, out_kidx
  );

  // The environment around the stage: upstream producer plus downstream consumer.
  modport master (
    output in_valid, in_data, in_kidx, out_ready,
    input  in_ready, out_valid, out_data, out_kidx
  );

endinterface

// File: rtl/addkey_keytab.sv
// Round-key register file: one synchronous write port, one asynchronous read port
// with write-first bypass, and range flags for both indices.
module addkey_keytab
  import aes_pkg::*;
#(
  parameter int BLOCK_W  = AES_BLOCK_W,
  parameter int NUM_KEYS = NK256,
  parameter int KIDX_W   = $clog2(NUM_KEYS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [KIDX_W-1:0]  widx,
  input  logic [BLOCK_W-1:0] wdata,
  input  logic [KIDX_W-1:0]  ridx,
  output logic [BLOCK_W-1:0] rdata,
  output logic               w_ok,
  output logic               r_ok
);

  logic [BLOCK_W-1:0] keys [NUM_KEYS];

  assign w_ok = (widx < KIDX_W'(NUM_KEYS));
  assign r_ok = (ridx < KIDX_W'(NUM_KEYS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) keys[k] <= '0;
    end else if (we && w_ok) begin
      for (int k = 0; k < NUM_KEYS; k++)
        if (widx == KIDX_W'(k)) keys[k] <= wdata;
    end
  end

  // Out-of-range reads yield zero so the block passes through unmodified; a
  // same-cycle write to the read index is forwarded (write-first).
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (ridx == KIDX_W'(k)) rdata = keys[k];
    if (we && w_ok && (widx == ridx)) rdata = wdata;
  end

endmodule

// File: rtl/addkey_stream.sv
// Streaming AES AddRoundKey stage: one elastic register stage XORing each block with
// a round key from an internal table, plus a sticky index-error flag and block counter.
module addkey_stream
  import aes_pkg::*;
#(
  parameter int BLOCK_W  = AES_BLOCK_W,
  parameter int NUM_KEYS = NK256,
  parameter int KIDX_W   = $clog2(NUM_KEYS + 1),
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kw_en,
  input  logic [KIDX_W-1:0]  kw_idx,
  input  logic [BLOCK_W-1:0] kw_data,
  input  logic               err_clr,
  output logic               err,
  output logic [CNT_W-1:0]   blk_cnt,
  addkey_stream_if.slave     s
);

  logic [BLOCK_W-1:0] key_eff;
  logic               kw_ok;
  logic               kidx_ok;
  logic               accept;
  logic               new_err;

  addkey_keytab #(
    .BLOCK_W (BLOCK_W),
    .NUM_KEYS(NUM_KEYS),
    .KIDX_W  (KIDX_W)
  ) u_keytab (
    .clk  (clk),
    .rst  (rst),
    .we   (kw_en),
    .widx (kw_idx),
    .wdata(kw_data),
    .ridx (s.in_kidx),
    .rdata(key_eff),
    .w_ok (kw_ok),
    .r_ok (kidx_ok)
  );

  assign s.in_ready = !s.out_valid || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;
  assign new_err    = (accept && !kidx_ok) || (kw_en && !kw_ok);

  // Output register only loads on accept, so a stalled block holds its data/index;
  // a new error outranks a clear so no error can slip through unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_kidx  <= '0;
      err         <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      if (accept) begin
        s.out_data  <= s.in_data ^ key_eff;
        s.out_kidx  <= s.in_kidx;
        s.out_valid <= 1'b1;
        blk_cnt     <= blk_cnt + CNT_W'(1);
      end else if (s.out_ready) begin
        s.out_valid <= 1'b0;
      end

      if (new_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule
